mac_signed_pipe: RTL and testbench
==================================

Name: mac_signed_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit.
- Sequential successor to the combinational acc_mult_signed<W1>x<W2> family.
- Accepts a stream of signed A×B beats (plus carry-in) and accumulates them into groups delimited by first/last flags.
- Emits one accumulated sum per group over a valid/ready handshake; used by datapath blocks needing dot products.

Parameters:
- WIDTH_A, 8, signed width of operand a.
- WIDTH_B, 8, signed width of operand b.
- GUARD, 4, extra accumulator guard bits; ACC_W = WIDTH_A+WIDTH_B+GUARD (localparam).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- a  in  WIDTH_A  signed operand.
- b  in  WIDTH_B  signed operand.
- cin  in  1  carry-in, added as +1 to this beat's product.
- first  in  1  beat starts a new group (accumulator cleared before add).
- last  in  1  beat closes the group; result is emitted.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  signed group sum.
- out_ovf  out  1  signed overflow occurred in this group.

Behaviour:
- Reset (async, rst_n=0): in_ready=0 while asserted, out_valid=0, out_sum=0, out_ovf=0; accumulator, stage-1 regs and ovf flag cleared; FSM to IDLE. Reset mid-group discards the group with no output.
- Handshake: a beat transfers when in_valid&&in_ready. A result transfers when out_valid&&out_ready.
- out_valid/out_sum/out_ovf hold stable until accepted.
- in_ready = rst released && !(out_valid && !out_ready): a global stall freezes both pipeline stages.
- Stage 1 (S1): register p = a*b, signed, full width WIDTH_A+WIDTH_B, sign-extended to ACC_W; also register cin, first, last and s1_valid.
- Stage 2 (S2), when s1_valid and not stalled:
  - base = first ? 0 : acc.
  - acc <= base + p + cin, mod 2^ACC_W.
  - Overflow = sign of base equals sign of p and differs from sign of the result. The cin contribution is included in the check.
  - ovf_flag <= (first ? 0 : ovf_flag) | overflow.
- Latency: a beat with last=1 accepted in cycle N gives out_valid=1 in cycle N+2. Throughput is 1 beat/cycle when not stalled.
- FSM (S2 view):
  - IDLE: no group open. Beat with first → ACC; if that beat also has last → OUT.
  - ACC: beats without first accumulate. Beat with last → OUT.
  - OUT: result registered, out_valid=1. On acceptance → IDLE. If an S1 beat is waiting and out_ready=1, it is processed the same cycle (back-to-back groups, no bubble).
- Boundary cases:
  - Beat in IDLE without first: treated as first (accumulator implicitly cleared).
  - first while in ACC: silently restarts the group; the previous partial sum is dropped.
  - first&&last on the same beat: single-product group; out_sum = a*b+cin.
  - Extreme operands, e.g. a=b=-2^(W-1): product computed at full width without truncation.
  - No wrap/sat for a single product; accumulation follows the selected overflow mode.

Optional Feature:
- Macro MAC_SIGNED_SAT_EN.
- Defined: on overflow, acc saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) according to the operand sign. It stays saturated for further same-direction adds; an opposite add proceeds from the saturated value. out_ovf is still set.
- Undefined: two's-complement wrap; out_ovf reports overflow.

Decomposition:
- Package mac_pkg:
  - FSM state enum (IDLE, ACC, OUT).
  - Function sat_add(base, addend, width) returning sum and overflow.
  - Constants for the saturation max/min per width.
- One sub-module: mac_mult_stage (S1 multiply register with stall enable).
- Accumulate/FSM logic stays in the top level.

Test Plan:
- Defaults, single group: beats (3,5,first), (-2,7), (4,-1,last), cin=0 → one result, out_sum=-3, out_ovf=0, exactly 2 cycles after the last beat.
- Extremes: four beats a=b=-128, first on beat 1, last on beat 4 → out_sum=65536 (fits ACC_W=20), out_ovf=0. Separately, single-beat first&&last with a=-128, b=127, cin=1 → out_sum=-16255.
- Overflow, GUARD=0 (ACC_W=16): (-128,-128,first), (-128,-128,last):
  - Without macro → out_sum=-32768, out_ovf=1.
  - With MAC_SIGNED_SAT_EN → out_sum=32767, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 → in_ready=0, out_sum stable. Next group (first&&last, 2×3) emits 6 only after the first result is accepted; no beat lost.
- Back-to-back: 3 consecutive single-beat groups (1×1, 2×2, 3×3) with out_ready=1 → results 1, 4, 9 on three consecutive cycles.
- Reset mid-group: assert rst_n=0 after 2 of 4 beats → out_valid=0 immediately. After release, a new group (5,5,first&&last) yields 25 with no residue.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the pipelined signed MAC.
// Holds the accumulate-stage FSM encoding, the saturation limits and the
// overflow-aware adder used by mac_signed_pipe (saturating mode is selected
// there with MAC_SIGNED_SAT_EN).
package mac_pkg;

  // Accumulate-stage view of the current group.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } mac_state_e;

  // Internal width for exact sums; any accumulator up to 62 bits fits.
  localparam int CALC_W = 64;

  typedef struct packed {
    logic signed [CALC_W-1:0] sum;
    logic                     ovf;
  } add_res_t;

  // Largest signed value representable in `width` bits.
  function automatic logic signed [CALC_W-1:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative signed value representable in `width` bits.
  function automatic logic signed [CALC_W-1:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  // Exact add, then flag results that do not fit in `width` bits.
  // The caller keeps the low `width` bits, so without saturation the
  // result wraps; with saturation it clamps toward the overflow direction.
  function automatic add_res_t sat_add(input logic signed [CALC_W-1:0] base,
                                       input logic signed [CALC_W-1:0] addend,
                                       input int                       width,
                                       input logic                     sat_en);
    add_res_t                 res;
    logic signed [CALC_W-1:0] exact;
    exact   = base + addend;
    res.ovf = (exact > sat_max(width)) || (exact < sat_min(width));
    res.sum = exact;
    if (sat_en && res.ovf) begin
      res.sum = exact[CALC_W-1] ? sat_min(width) : sat_max(width);
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Stage 1 of the MAC: registers the full-width signed product a*b,
// sign-extended to the accumulator width, together with the beat's
// carry-in and group flags. i_en low freezes the whole stage.
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8,
  parameter int ACC_W   = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic [WIDTH_A-1:0]       i_a,
  input  logic [WIDTH_B-1:0]       i_b,
  input  logic                     i_cin,
  input  logic                     i_first,
  input  logic                     i_last,
  output logic                     o_valid,
  output logic signed [ACC_W-1:0]  o_p,
  output logic                     o_cin,
  output logic                     o_first,
  output logic                     o_last
);

  localparam int PROD_W = WIDTH_A + WIDTH_B;

  logic signed [PROD_W-1:0] w_prod;

  // Both operands widened with sign before multiplying: no truncation even
  // for the most negative operand pair.
  assign w_prod = PROD_W'($signed(i_a)) * PROD_W'($signed(i_b));

  // Capture the beat whenever the pipeline is advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_p     <= '0;
      o_cin   <= 1'b0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_p     <= ACC_W'(w_prod);
      o_cin   <= i_cin;
      o_first <= i_first;
      o_last  <= i_last;
    end
  end

endmodule

// File: rtl/mac_signed_pipe.sv
// Pipelined signed multiply-accumulate: S1 multiplies, S2 accumulates beats
// into groups delimited by first/last and presents one sum per group.
// Build option: define MAC_SIGNED_SAT_EN for a saturating accumulator;
// otherwise the accumulator wraps in two's complement. out_ovf flags
// overflow in either build.
//
// Handshake: a beat moves on in_valid && in_ready, a result on
// out_valid && out_ready. While a result waits (out_valid && !out_ready)
// both stages freeze and in_ready is low; out_valid/out_sum/out_ovf stay
// stable until taken.
module mac_signed_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8,
  parameter int GUARD   = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH_A-1:0]                 a,
  input  logic [WIDTH_B-1:0]                 b,
  input  logic                               cin,
  input  logic                               first,
  input  logic                               last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH_A+WIDTH_B+GUARD-1:0]   out_sum,
  output logic                               out_ovf,
  output logic [1:0]                         o_dbg_state
);

  localparam int ACC_W = WIDTH_A + WIDTH_B + GUARD;

`ifdef MAC_SIGNED_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic                     r_run;
  logic                     w_stall;
  logic                     w_accept;
  mac_state_e               r_state;
  mac_state_e               w_state_next;

  logic                     w_s1_valid;
  logic signed [ACC_W-1:0]  w_s1_p;
  logic                     w_s1_cin;
  logic                     w_s1_first;
  logic                     w_s1_last;

  logic                     w_process;
  logic                     w_eff_first;
  logic signed [ACC_W-1:0]  w_base;
  add_res_t                 w_res;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic                     w_ovf_next;
  logic [CALC_W-ACC_W-1:0]  w_unused_hi;

  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_ovf_flag;
  logic signed [ACC_W-1:0]  r_sum;
  logic                     r_ovf;

  assign w_stall     = out_valid && !out_ready;
  assign in_ready    = r_run && !w_stall;
  assign w_accept    = in_valid && in_ready;
  assign out_sum     = r_sum;
  assign out_ovf     = r_ovf;
  assign o_dbg_state = r_state;

  // Holds in_ready low until the first clock after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  mac_mult_stage #(
    .WIDTH_A (WIDTH_A),
    .WIDTH_B (WIDTH_B),
    .ACC_W   (ACC_W)
  ) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (in_ready),
    .i_valid (w_accept),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .i_first (first),
    .i_last  (last),
    .o_valid (w_s1_valid),
    .o_p     (w_s1_p),
    .o_cin   (w_s1_cin),
    .o_first (w_s1_first),
    .o_last  (w_s1_last)
  );

  // A beat arriving with no group open (IDLE, or right after a result)
  // starts a fresh group even without its first flag.
  assign w_process   = w_s1_valid && !w_stall;
  assign w_eff_first = w_s1_first || (r_state != ACC);
  assign w_base      = w_eff_first ? '0 : r_acc;
  assign w_res       = sat_add(CALC_W'(w_base),
                               CALC_W'(w_s1_p) + CALC_W'($signed({1'b0, w_s1_cin})),
                               ACC_W, SAT_EN);
  assign w_acc_next  = w_res.sum[ACC_W-1:0];
  assign w_unused_hi = w_res.sum[CALC_W-1:ACC_W];
  assign w_ovf_next  = (w_eff_first ? 1'b0 : r_ovf_flag) | w_res.ovf;

  // Running group sum and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_ovf_flag <= 1'b0;
    end else if (w_process) begin
      r_acc      <= w_acc_next;
      r_ovf_flag <= w_ovf_next;
    end
  end

  // Result register: loaded when the closing beat of a group is added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (w_process && w_s1_last) begin
      r_sum <= w_acc_next;
      r_ovf <= w_ovf_next;
    end
  end

  // Group FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; out_valid is simply "a result is being presented".
  always_comb begin
    w_state_next = r_state;
    out_valid    = (r_state == OUT);
    case (r_state)
      IDLE: begin
        if (w_process) w_state_next = w_s1_last ? OUT : ACC;
      end
      ACC: begin
        if (w_process && w_s1_last) w_state_next = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (w_process) w_state_next = w_s1_last ? OUT : ACC;
          else           w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_signed_pipe.sv
// Bench for mac_signed_pipe: a default instance (ACC_W=20) and a GUARD=0
// instance (ACC_W=16) share one input stream. A group-level arithmetic model
// predicts every result; monitors compare each accepted result in order.
module tb_mac_signed_pipe;

  localparam int ACC1 = 20;
  localparam int ACC0 = 16;

`ifdef MAC_SIGNED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic              in_valid = 1'b0;
  logic signed [7:0] a = '0;
  logic signed [7:0] b = '0;
  logic              cin = 1'b0;
  logic              first = 1'b0;
  logic              last = 1'b0;
  logic              out_ready = 1'b0;

  logic                   in_ready, out_valid, out_ovf;
  logic signed [ACC1-1:0] out_sum;
  logic [1:0]             dbg_state;
  logic                   in_ready0, out_valid0, out_ovf0;
  logic signed [ACC0-1:0] out_sum0;
  logic [1:0]             dbg_state0;

  mac_signed_pipe #(.WIDTH_A(8), .WIDTH_B(8), .GUARD(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .first(first), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .o_dbg_state(dbg_state)
  );

  mac_signed_pipe #(.WIDTH_A(8), .WIDTH_B(8), .GUARD(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .cin(cin), .first(first), .last(last),
    .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
    .out_ovf(out_ovf0), .o_dbg_state(dbg_state0)
  );

  // out_ready: fixed level from ready_ctl, or random backpressure.
  bit rand_bp = 1'b0;
  bit ready_ctl = 1'b1;
  always @(posedge clk) begin
    #2;
    out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : ready_ctl;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [ACC1:0] exp_q[$];   // {ovf, sum} for ACC_W=20
  logic [ACC0:0] exp0_q[$];  // {ovf, sum} for ACC_W=16
  int unsigned   out_cyc_q[$];

  // Group model: open flag, running sum and overflow flag per width.
  bit     m_open[2];
  longint m_acc[2];
  bit     m_ovf[2];

  task automatic model_beat(input int op_a, input int op_b, input bit tc,
                            input bit tf, input bit tl);
    for (int k = 0; k < 2; k++) begin
      longint w, mx, mn, s;
      w  = (k == 0) ? ACC1 : ACC0;
      mx = (64'sd1 <<< (w - 1)) - 1;
      mn = -mx - 1;
      if (tf || !m_open[k]) begin
        m_acc[k] = 0;
        m_ovf[k] = 1'b0;
      end
      s = m_acc[k] + longint'(op_a) * longint'(op_b) + longint'(tc);
      if (s > mx || s < mn) begin
        m_ovf[k] = 1'b1;
        if (SAT) s = (s > mx) ? mx : mn;
        else     s = (s > mx) ? s - (mx - mn + 1) : s + (mx - mn + 1);
      end
      m_acc[k]  = s;
      m_open[k] = !tl;
      if (tl) begin
        if (k == 0) exp_q.push_back({m_ovf[k], ACC1'(s)});
        else        exp0_q.push_back({m_ovf[k], ACC0'(s)});
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp0_q.delete();
    for (int k = 0; k < 2; k++) begin
      m_open[k] = 1'b0;
      m_acc[k]  = 0;
      m_ovf[k]  = 1'b0;
    end
  endtask

  // Result monitors: sample at negedge, one check set per transfer.
  always @(negedge clk) begin
    logic [ACC1:0] e;
    if (rst_n && out_valid && out_ready) begin
      check("q20_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sum20", out_sum, $signed(e[ACC1-1:0]));
        check("ovf20", out_ovf, e[ACC1]);
        out_cyc_q.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    logic [ACC0:0] e;
    if (rst_n && out_valid0 && out_ready) begin
      check("q16_nonempty", exp0_q.size() > 0, 1);
      if (exp0_q.size() > 0) begin
        e = exp0_q.pop_front();
        check("sum16", out_sum0, $signed(e[ACC0-1:0]));
        check("ovf16", out_ovf0, e[ACC0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end 1ns after a rising edge.
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int op_a, input int op_b, input bit tc,
                           input bit tf, input bit tl);
    bit ok;
    int n;
    n        = 0;
    a        = 8'(op_a);
    b        = 8'(op_b);
    cin      = tc;
    first    = tf;
    last     = tl;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    check("beat_accept", ok, 1);
    if (ok) model_beat(op_a, op_b, tc, tf, tl);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp0_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", exp_q.size() + exp0_q.size(), 0);
    sync();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base_idx;
    bit seen;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    sync();
    check("ready_after_rst", in_ready, 1);

    // Single group with exact two-cycle latency.
    send_beat(3, 5, 0, 1, 0);
    send_beat(-2, 7, 0, 0, 0);
    send_beat(4, -1, 0, 0, 1);
    @(negedge clk);
    check("lat_n1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_n2_valid", out_valid, 1);
    check("lat_sum", out_sum, -3);
    check("lat_ovf", out_ovf, 0);
    sync();
    drain();

    // Extreme operands; overflow in the 16-bit instance.
    send_beat(-128, -128, 0, 1, 0);
    send_beat(-128, -128, 0, 0, 0);
    send_beat(-128, -128, 0, 0, 0);
    send_beat(-128, -128, 0, 0, 1);
    send_beat(-128, 127, 1, 1, 1);
    send_beat(-128, -128, 0, 1, 0);
    send_beat(-128, -128, 0, 0, 1);
    drain();

    // Restart with first inside a group; beat without first after a result.
    send_beat(2, 2, 0, 1, 0);
    send_beat(3, 3, 0, 1, 1);
    send_beat(4, 4, 0, 0, 1);
    drain();

    // Backpressure: result held five cycles, next group waits.
    ready_ctl = 1'b0;
    send_beat(4, 4, 0, 1, 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("bp_valid_seen", seen, 1);
    sync();
    fork
      send_beat(2, 3, 0, 1, 1);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
          check("bp_out_sum", out_sum, 16);
        end
        ready_ctl = 1'b1;
      end
    join
    drain();

    // Back-to-back single-beat groups on consecutive cycles.
    base_idx = out_cyc_q.size();
    send_beat(1, 1, 0, 1, 1);
    send_beat(2, 2, 0, 1, 1);
    send_beat(3, 3, 0, 1, 1);
    drain();
    check("b2b_count", out_cyc_q.size() - base_idx, 3);
    if (out_cyc_q.size() >= base_idx + 3) begin
      check("b2b_gap1", out_cyc_q[base_idx+1] - out_cyc_q[base_idx], 1);
      check("b2b_gap2", out_cyc_q[base_idx+2] - out_cyc_q[base_idx+1], 1);
    end

    // Reset in the middle of a group.
    send_beat(1, 2, 0, 1, 0);
    send_beat(3, 4, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    model_reset();
    sync();
    sync();
    rst_n = 1'b1;
    sync();
    send_beat(5, 5, 0, 1, 1);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_sum", out_sum, 25);
    sync();
    drain();

    // Random beats under random backpressure and input gaps.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) sync();
      send_beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                bit'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0);
    end
    send_beat(1, 1, 0, 0, 1);
    rand_bp = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
